// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared types and arithmetic helpers for the pooling stage
package lenet_pkg;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_t;

  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_SHIFT     = 8;
  localparam int DEF_MAP_W     = 28;
  localparam int DEF_MAP_H     = 28;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_COL_W = cnt_width(DEF_MAP_W);
  localparam int DEF_ROW_W = cnt_width(DEF_MAP_H);

  function automatic logic signed [63:0] smax(input logic signed [63:0] a,
                                              input logic signed [63:0] b);
    return (a > b) ? a : b;
  endfunction

  // ReLU, arithmetic rescale by truncation, then clamp to the positive output range.
  function automatic logic signed [63:0] requant(input logic signed [63:0] v,
                                                 input int shift,
                                                 input int out_width);
    logic signed [63:0] s;
    logic signed [63:0] lim;
    if (v < 0) return '0;
    s   = v >>> shift;
    lim = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// rtl/pool_row_buf.sv - horizontal-max line store, one write port and one async read port
module pool_row_buf
  import lenet_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int WIDTH = 32,
  parameter int ADDR_W = cnt_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic signed [WIDTH-1:0] wdata,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/relu_maxpool22.sv
// rtl/relu_maxpool22.sv - ReLU + 2x2/stride-2 max-pool + requantisation of a raster conv stream
module relu_maxpool22
  import lenet_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int MAP_W     = DEF_MAP_W,
  parameter int MAP_H     = DEF_MAP_H
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_value,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_value,
  output logic                        frame_done
);

  localparam int COL_W  = cnt_width(MAP_W);
  localparam int ROW_W  = cnt_width(MAP_H);
  localparam int DEPTH  = MAP_W / 2;
  localparam int ADDR_W = cnt_width(DEPTH);

  generate
    if ((MAP_W % 2) != 0 || MAP_W < 2 || (MAP_H % 2) != 0 || MAP_H < 2) begin : g_bad_map
      $error("relu_maxpool22: MAP_W and MAP_H must be even and >= 2");
    end
  endgenerate

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  row_state_t               state, state_nx;
  logic signed [IN_WIDTH-1:0] pair_reg, hmax, vmax, rb_rdata;
  logic [ADDR_W-1:0]        rb_addr;
  logic accept, col_last, row_last, rb_we, win_done;

  assign accept   = in_valid && !clear;
  assign col_last = (col == COL_W'(MAP_W - 1));
  assign row_last = (row == ROW_W'(MAP_H - 1));
  assign rb_addr  = ADDR_W'(col >> 1);

  assign hmax = IN_WIDTH'(smax(64'(pair_reg), 64'(in_value)));
  assign vmax = IN_WIDTH'(smax(64'(rb_rdata), 64'(hmax)));

  pool_row_buf #(
    .DEPTH (DEPTH),
    .WIDTH (IN_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_row_buf (
    .clk  (clk),
    .we   (rb_we),
    .addr (rb_addr),
    .wdata(hmax),
    .rdata(rb_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ROW_EVEN;
    else      state <= state_nx;
  end

  // Even rows park their horizontal max; odd rows complete the window.
  always_comb begin
    state_nx = state;
    rb_we    = 1'b0;
    win_done = 1'b0;
    if (clear) begin
      state_nx = ROW_EVEN;
    end else if (accept) begin
      if (col[0]) begin
        rb_we    = (state == ROW_EVEN);
        win_done = (state == ROW_ODD);
      end
      if (col_last) begin
        if (row_last)               state_nx = ROW_EVEN;
        else if (state == ROW_EVEN) state_nx = ROW_ODD;
        else                        state_nx = ROW_EVEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      pair_reg   <= '0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= win_done;
      frame_done <= win_done && row_last && col_last;
      if (win_done) out_value <= OUT_WIDTH'(requant(64'(vmax), SHIFT, OUT_WIDTH));
      if (clear) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (!col[0]) pair_reg <= in_value;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule
